regfile_write_arbiter: RTL

Shares the single write port of the 32-bit general-purpose register file between two write-back sources: requester 0 (ALU result path) and requester 1 (memory-load path). Grants are round-robin with a valid/ready handshake. The accepted write is registered and presented to the register file one cycle later. A stall input freezes granting, and a saturating counter records cycles in which both sources contended.

---
 rtl/regfile_write_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU
// write-back path (requester 0) and the memory-load path (requester 1).
module regfile_write_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_src,
  output logic [CNT_W-1:0]  contention_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    logic [CNT_W-1:0] res;
    if (val == CNT_MAX) begin
      res = val;
    end else begin
      res = val + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

  logic              last_grant_r;
  logic              grant0_s;
  logic              grant1_s;
  logic              xfer_s;
  logic              contend_s;
  logic              win_src_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [DATA_W-1:0] win_data_s;

  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [DATA_W-1:0] wr_data_r;
  logic              wr_src_r;
  logic [CNT_W-1:0]  cnt_r;

  // Grant selection: reset and hold block all grants; a tie goes to the
  // requester that did not win the previous transfer.
  always_comb begin
    grant0_s  = 1'b0;
    grant1_s  = 1'b0;
    contend_s = req0_valid & req1_valid & ~hold;
    if (reset || hold) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (req0_valid && req1_valid) begin
      if (last_grant_r) begin
        grant0_s = 1'b1;
      end else begin
        grant1_s = 1'b1;
      end
    end else if (req0_valid) begin
      grant0_s = 1'b1;
    end else if (req1_valid) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Winner payload mux; the grant is one-hot or empty by construction.
  always_comb begin
    win_src_s  = 1'b0;
    win_addr_s = {ADDR_W{1'b0}};
    win_data_s = {DATA_W{1'b0}};
    case ({grant1_s, grant0_s})
      2'b01: begin
        win_src_s  = 1'b0;
        win_addr_s = req0_addr;
        win_data_s = req0_data;
      end
      2'b10: begin
        win_src_s  = 1'b1;
        win_addr_s = req1_addr;
        win_data_s = req1_data;
      end
      default: begin
        win_src_s  = 1'b0;
        win_addr_s = {ADDR_W{1'b0}};
        win_data_s = {DATA_W{1'b0}};
      end
    endcase
  end

  assign xfer_s     = grant0_s | grant1_s;
  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;

  // Write stage; register 0 is hardwired, so its writes are accepted but dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_r   <= 1'b0;
      wr_addr_r <= {ADDR_W{1'b0}};
      wr_data_r <= {DATA_W{1'b0}};
      wr_src_r  <= 1'b0;
    end else if (xfer_s) begin
      wr_en_r   <= (win_addr_s != {ADDR_W{1'b0}});
      wr_addr_r <= win_addr_s;
      wr_data_r <= win_data_s;
      wr_src_r  <= win_src_s;
    end else begin
      wr_en_r   <= 1'b0;
    end
  end

  // Fairness pointer moves only on a real transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_r <= 1'b1;
    end else if (xfer_s) begin
      last_grant_r <= win_src_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // Contention counter: counts un-held cycles with both sources pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (contend_s) begin
      cnt_r <= sat_inc(cnt_r);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign wr_en          = wr_en_r;
  assign wr_addr        = wr_addr_r;
  assign wr_data        = wr_data_r;
  assign wr_src         = wr_src_r;
  assign contention_cnt = cnt_r;

endmodule
